reorder_buffer: RTL and testbench

- Single-dispatch, single-completion, single-commit reorder buffer for the out-of-order core.
- Each in-flight instruction owns one entry, indexed by its rename-register-file (RRF) tag.
- The buffer records PC and architectural destination at dispatch and is marked finished when ALU1 completes.
- It retires entries strictly in order from a circular commit pointer, producing the architectural-register write enable and destination.

---
 rtl/reorder_buffer.sv | 96 +++++++++
 tb/tb_reorder_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Reorder buffer: one entry per RRF tag, in-order retirement from a circular head pointer.
// Optional macro ROB_COMMIT_PC_EN adds pc_com_1_o carrying the committing entry's PC.
module reorder_buffer #(
    parameter int INSN_LEN = 32,
    parameter int REG_SEL  = 5,
    parameter int RRF_SEL  = 6,
    parameter int ROB_SEL  = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dp1_i,
    input  logic [RRF_SEL-1:0]  dp1_addr_i,
    input  logic [INSN_LEN-1:0] pc_dp1_i,
    input  logic                dstvalid_dp1_i,
    input  logic [REG_SEL-1:0]  dst_dp1_i,
    input  logic                finish_ex_alu1_i,
    input  logic [RRF_SEL-1:0]  finish_ex_alu1_addr_i,
`ifdef ROB_COMMIT_PC_EN
    output logic [INSN_LEN-1:0] pc_com_1_o,
`endif
    output logic [ROB_SEL-1:0]  commit_ptr_1_o,
    output logic                com_en_1_o,
    output logic                arfwe_1_o,
    output logic [REG_SEL-1:0]  dst_arf_1_o
);

    localparam int ENTRIES = 2**RRF_SEL;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] finished_q, finished_d;
    logic [ENTRIES-1:0] dstvalid_q;
    logic [REG_SEL-1:0] dst_q [ENTRIES];
    logic [ROB_SEL-1:0] ptr_q, ptr_d;
    logic               com_en;

    assign com_en         = valid_q[ptr_q] & finished_q[ptr_q];
    assign com_en_1_o     = com_en;
    assign commit_ptr_1_o = ptr_q;
    assign arfwe_1_o      = com_en & dstvalid_q[ptr_q];
    assign dst_arf_1_o    = com_en ? dst_q[ptr_q] : '0;

    // Order matters: completion, then commit clear, then dispatch, so dispatch always wins.
    always_comb begin
        valid_d    = valid_q;
        finished_d = finished_q;
        ptr_d      = ptr_q;
        if (finish_ex_alu1_i && valid_q[finish_ex_alu1_addr_i]) begin
            finished_d[finish_ex_alu1_addr_i] = 1'b1;
        end
        if (com_en) begin
            valid_d[ptr_q]    = 1'b0;
            finished_d[ptr_q] = 1'b0;
            ptr_d             = ptr_q + ROB_SEL'(1);
        end
        if (dp1_i) begin
            valid_d[dp1_addr_i]    = 1'b1;
            finished_d[dp1_addr_i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= '0;
            finished_q <= '0;
            ptr_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            finished_q <= finished_d;
            ptr_q      <= ptr_d;
        end
    end

    // Payload fields carry no reset; they are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (dp1_i) begin
            dstvalid_q[dp1_addr_i] <= dstvalid_dp1_i;
            dst_q[dp1_addr_i]      <= dst_dp1_i;
        end
    end

`ifdef ROB_COMMIT_PC_EN
    logic [INSN_LEN-1:0] pc_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (dp1_i) begin
            pc_q[dp1_addr_i] <= pc_dp1_i;
        end
    end

    assign pc_com_1_o = com_en ? pc_q[ptr_q] : '0;
`else
    logic [INSN_LEN-1:0] unused_pc;
    assign unused_pc = pc_dp1_i;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: reset, commit paths, ordering, wrap and dispatch priority.
module tb_reorder_buffer;

    localparam int INSN_LEN = 32;
    localparam int REG_SEL  = 5;
    localparam int RRF_SEL  = 6;
    localparam int ROB_SEL  = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic                dp1_i;
    logic [RRF_SEL-1:0]  dp1_addr_i;
    logic [INSN_LEN-1:0] pc_dp1_i;
    logic                dstvalid_dp1_i;
    logic [REG_SEL-1:0]  dst_dp1_i;
    logic                finish_ex_alu1_i;
    logic [RRF_SEL-1:0]  finish_ex_alu1_addr_i;
    logic [ROB_SEL-1:0]  commit_ptr_1_o;
    logic                com_en_1_o;
    logic                arfwe_1_o;
    logic [REG_SEL-1:0]  dst_arf_1_o;
`ifdef ROB_COMMIT_PC_EN
    logic [INSN_LEN-1:0] pc_com_1_o;
`endif

    int errors = 0;
    int checks = 0;

    reorder_buffer #(
        .INSN_LEN(INSN_LEN), .REG_SEL(REG_SEL), .RRF_SEL(RRF_SEL), .ROB_SEL(ROB_SEL)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .dp1_i                 (dp1_i),
        .dp1_addr_i            (dp1_addr_i),
        .pc_dp1_i              (pc_dp1_i),
        .dstvalid_dp1_i        (dstvalid_dp1_i),
        .dst_dp1_i             (dst_dp1_i),
        .finish_ex_alu1_i      (finish_ex_alu1_i),
        .finish_ex_alu1_addr_i (finish_ex_alu1_addr_i),
`ifdef ROB_COMMIT_PC_EN
        .pc_com_1_o            (pc_com_1_o),
`endif
        .commit_ptr_1_o        (commit_ptr_1_o),
        .com_en_1_o            (com_en_1_o),
        .arfwe_1_o             (arfwe_1_o),
        .dst_arf_1_o           (dst_arf_1_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dp1_i = 1'b0; dp1_addr_i = '0; pc_dp1_i = '0; dstvalid_dp1_i = 1'b0; dst_dp1_i = '0;
        finish_ex_alu1_i = 1'b0; finish_ex_alu1_addr_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic dispatch(input logic [RRF_SEL-1:0] a, input logic [INSN_LEN-1:0] pc,
                            input logic dv, input logic [REG_SEL-1:0] d);
        dp1_i = 1'b1; dp1_addr_i = a; pc_dp1_i = pc; dstvalid_dp1_i = dv; dst_dp1_i = d;
    endtask

    task automatic finish(input logic [RRF_SEL-1:0] a);
        finish_ex_alu1_i = 1'b1; finish_ex_alu1_addr_i = a;
    endtask

    task automatic test_reset();
        do_reset();
        dispatch(6'd0, 32'h40, 1'b1, 5'd3); tick(); idle_inputs();
        finish(6'd0); tick(); idle_inputs();
        checks++; if (com_en_1_o !== 1'b1) begin errors++; $display("FAIL rst_pre_com_en: got %b want 1", com_en_1_o); end
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            dp1_i = 1'($urandom_range(0, 1)); dp1_addr_i = RRF_SEL'($urandom_range(0, 63));
            pc_dp1_i = $urandom; dstvalid_dp1_i = 1'($urandom_range(0, 1)); dst_dp1_i = REG_SEL'($urandom_range(0, 31));
            finish_ex_alu1_i = 1'($urandom_range(0, 1)); finish_ex_alu1_addr_i = RRF_SEL'($urandom_range(0, 63));
            tick();
        end
        reset = 1'b1;
        idle_inputs();
        checks++; if (commit_ptr_1_o !== 6'd0) begin errors++; $display("FAIL rst_ptr: got %0d want 0", commit_ptr_1_o); end
        checks++; if (com_en_1_o !== 1'b0) begin errors++; $display("FAIL rst_com_en: got %b want 0", com_en_1_o); end
        checks++; if (arfwe_1_o !== 1'b0) begin errors++; $display("FAIL rst_arfwe: got %b want 0", arfwe_1_o); end
        checks++; if (dst_arf_1_o !== 5'd0) begin errors++; $display("FAIL rst_dst: got %0d want 0", dst_arf_1_o); end
        tick();
        checks++; if (com_en_1_o !== 1'b0) begin errors++; $display("FAIL rst_empty_com_en: got %b want 0", com_en_1_o); end
        checks++; if (commit_ptr_1_o !== 6'd0) begin errors++; $display("FAIL rst_empty_ptr: got %0d want 0", commit_ptr_1_o); end
    endtask

    task automatic test_basic_commit();
        do_reset();
        dispatch(6'd0, 32'h100, 1'b1, 5'd5); tick(); idle_inputs();
        finish(6'd0);
        checks++; if (com_en_1_o !== 1'b0) begin errors++; $display("FAIL basic_unfinished: got %b want 0", com_en_1_o); end
        tick(); idle_inputs();
        checks++; if (com_en_1_o !== 1'b1) begin errors++; $display("FAIL basic_com_en: got %b want 1", com_en_1_o); end
        checks++; if (arfwe_1_o !== 1'b1) begin errors++; $display("FAIL basic_arfwe: got %b want 1", arfwe_1_o); end
        checks++; if (dst_arf_1_o !== 5'd5) begin errors++; $display("FAIL basic_dst: got %0d want 5", dst_arf_1_o); end
        checks++; if (commit_ptr_1_o !== 6'd0) begin errors++; $display("FAIL basic_ptr0: got %0d want 0", commit_ptr_1_o); end
`ifdef ROB_COMMIT_PC_EN
        checks++; if (pc_com_1_o !== 32'h100) begin errors++; $display("FAIL basic_pc: got %h want 100", pc_com_1_o); end
`endif
        tick();
        checks++; if (commit_ptr_1_o !== 6'd1) begin errors++; $display("FAIL basic_ptr1: got %0d want 1", commit_ptr_1_o); end
        checks++; if (com_en_1_o !== 1'b0) begin errors++; $display("FAIL basic_after: got %b want 0", com_en_1_o); end
        checks++; if (dst_arf_1_o !== 5'd0) begin errors++; $display("FAIL basic_dst_idle: got %0d want 0", dst_arf_1_o); end
    endtask

    task automatic test_no_dest();
        do_reset();
        dispatch(6'd0, 32'h200, 1'b0, 5'd7); tick(); idle_inputs();
        finish(6'd0); tick(); idle_inputs();
        checks++; if (com_en_1_o !== 1'b1) begin errors++; $display("FAIL nodest_com_en: got %b want 1", com_en_1_o); end
        checks++; if (arfwe_1_o !== 1'b0) begin errors++; $display("FAIL nodest_arfwe: got %b want 0", arfwe_1_o); end
        checks++; if (dst_arf_1_o !== 5'd7) begin errors++; $display("FAIL nodest_dst: got %0d want 7", dst_arf_1_o); end
        tick();
        checks++; if (commit_ptr_1_o !== 6'd1) begin errors++; $display("FAIL nodest_ptr: got %0d want 1", commit_ptr_1_o); end
    endtask

    task automatic test_ooo_finish();
        do_reset();
        dispatch(6'd0, 32'h300, 1'b1, 5'd1); tick();
        dispatch(6'd1, 32'h304, 1'b1, 5'd2); tick();
        dispatch(6'd2, 32'h308, 1'b1, 5'd3); tick(); idle_inputs();
        finish(6'd2); tick();
        checks++; if (com_en_1_o !== 1'b0) begin errors++; $display("FAIL ooo_wait2: got %b want 0", com_en_1_o); end
        finish(6'd1); tick();
        checks++; if (com_en_1_o !== 1'b0) begin errors++; $display("FAIL ooo_wait1: got %b want 0", com_en_1_o); end
        finish(6'd0);
        checks++; if (com_en_1_o !== 1'b0) begin errors++; $display("FAIL ooo_latency: got %b want 0", com_en_1_o); end
        tick(); idle_inputs();
        for (int k = 0; k < 3; k++) begin
            checks++; if (com_en_1_o !== 1'b1) begin errors++; $display("FAIL ooo_com_en%0d: got %b want 1", k, com_en_1_o); end
            checks++; if (commit_ptr_1_o !== 6'(k)) begin errors++; $display("FAIL ooo_ptr%0d: got %0d want %0d", k, commit_ptr_1_o, k); end
            checks++; if (dst_arf_1_o !== 5'(k + 1)) begin errors++; $display("FAIL ooo_dst%0d: got %0d want %0d", k, dst_arf_1_o, k + 1); end
            tick();
        end
        checks++; if (com_en_1_o !== 1'b0) begin errors++; $display("FAIL ooo_done: got %b want 0", com_en_1_o); end
        checks++; if (commit_ptr_1_o !== 6'd3) begin errors++; $display("FAIL ooo_ptr_end: got %0d want 3", commit_ptr_1_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            dispatch(6'(i), 32'(i * 4), 1'b1, 5'(i % 32));
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 64; i++) begin
            finish(6'(i));
            if (i == 1) dispatch(6'd0, 32'hABC, 1'b1, 5'd9);
            else dp1_i = 1'b0;
            if (i > 0) begin
                checks++; if (com_en_1_o !== 1'b1) begin errors++; $display("FAIL wrap_com_en%0d: got %b want 1", i - 1, com_en_1_o); end
                checks++; if (commit_ptr_1_o !== 6'(i - 1)) begin errors++; $display("FAIL wrap_ptr%0d: got %0d want %0d", i - 1, commit_ptr_1_o, i - 1); end
                checks++; if (dst_arf_1_o !== 5'((i - 1) % 32)) begin errors++; $display("FAIL wrap_dst%0d: got %0d want %0d", i - 1, dst_arf_1_o, (i - 1) % 32); end
            end
            tick();
        end
        idle_inputs();
        checks++; if (com_en_1_o !== 1'b1) begin errors++; $display("FAIL wrap_com_en63: got %b want 1", com_en_1_o); end
        checks++; if (commit_ptr_1_o !== 6'd63) begin errors++; $display("FAIL wrap_ptr63: got %0d want 63", commit_ptr_1_o); end
        checks++; if (dst_arf_1_o !== 5'd31) begin errors++; $display("FAIL wrap_dst63: got %0d want 31", dst_arf_1_o); end
        tick();
        checks++; if (commit_ptr_1_o !== 6'd0) begin errors++; $display("FAIL wrap_ptr_to0: got %0d want 0", commit_ptr_1_o); end
        checks++; if (com_en_1_o !== 1'b0) begin errors++; $display("FAIL wrap_e0_unfinished: got %b want 0", com_en_1_o); end
        finish(6'd0); tick(); idle_inputs();
        checks++; if (com_en_1_o !== 1'b1) begin errors++; $display("FAIL wrap_e0_kept: got %b want 1", com_en_1_o); end
        checks++; if (dst_arf_1_o !== 5'd9) begin errors++; $display("FAIL wrap_e0_dst: got %0d want 9", dst_arf_1_o); end
        checks++; if (arfwe_1_o !== 1'b1) begin errors++; $display("FAIL wrap_e0_arfwe: got %b want 1", arfwe_1_o); end
        tick();
        checks++; if (commit_ptr_1_o !== 6'd1) begin errors++; $display("FAIL wrap_ptr_end: got %0d want 1", commit_ptr_1_o); end
    endtask

    task automatic test_dispatch_finish_same();
        do_reset();
        dispatch(6'd0, 32'h500, 1'b1, 5'd4); tick();
        dispatch(6'd0, 32'h504, 1'b1, 5'd6); finish(6'd0); tick(); idle_inputs();
        checks++; if (com_en_1_o !== 1'b0) begin errors++; $display("FAIL same_unfinished: got %b want 0", com_en_1_o); end
        tick();
        checks++; if (com_en_1_o !== 1'b0) begin errors++; $display("FAIL same_still_waiting: got %b want 0", com_en_1_o); end
        finish(6'd0); tick(); idle_inputs();
        checks++; if (com_en_1_o !== 1'b1) begin errors++; $display("FAIL same_com_en: got %b want 1", com_en_1_o); end
        checks++; if (dst_arf_1_o !== 5'd6) begin errors++; $display("FAIL same_dst: got %0d want 6", dst_arf_1_o); end
        tick();
        checks++; if (commit_ptr_1_o !== 6'd1) begin errors++; $display("FAIL same_ptr: got %0d want 1", commit_ptr_1_o); end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_commit();
        test_no_dest();
        test_ooo_finish();
        test_wrap();
        test_dispatch_finish_same();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
